tron_pixel_gen: RTL



---
 rtl/tron_pkg.sv | 37 +++
 rtl/tron_color_map.sv | 28 ++
 rtl/tron_pixel_gen.sv | 124 ++++++++++++
 3 files changed

// File: rtl/tron_pkg.sv
// Shared Tron arena definitions: grid geometry, cell codes, colours and
// the cell-address helper used by the pixel pipeline and the game logic.
package tron_pkg;

   localparam int GRID_W     = 80;
   localparam int GRID_H     = 60;
   localparam int CELL_SHIFT = 3;
   localparam int COL_W      = 7;
   localparam int ROW_W      = 6;
   localparam int ADDR_W     = 13;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'd0,
      CELL_P1    = 2'd1,
      CELL_P2    = 2'd2,
      CELL_WALL  = 2'd3
   } cell_t;

   localparam logic [7:0] COL_BLACK = 8'h00;
   localparam logic [7:0] COL_P1    = 8'h1F;
   localparam logic [7:0] COL_P2    = 8'hF0;
   localparam logic [7:0] COL_WALL  = 8'h92;
   localparam logic [7:0] COL_HEAD  = 8'hFF;

   // row*GRID_W+col; the 80-wide grid uses two shifts instead of a multiplier
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
      logic [ADDR_W-1:0] a;
      if (GRID_W == 80) begin
         a = (ADDR_W'(row) << 6) + (ADDR_W'(row) << 4) + ADDR_W'(col);
      end else begin
         a = ADDR_W'(row) * ADDR_W'(GRID_W) + ADDR_W'(col);
      end
      return a;
   endfunction

endpackage

// File: rtl/tron_color_map.sv
// Combinational cell code + head + active -> RRRGGGBB colour.
module tron_color_map
   import tron_pkg::*;
(
   input  logic [1:0] i_code,
   input  logic       i_head,
   input  logic       i_active,
   output logic [7:0] o_rgb
);

   // Blanking beats heads, heads beat whatever trail or wall lies beneath
   always_comb begin
      o_rgb = COL_BLACK;
      if (!i_active) begin
         o_rgb = COL_BLACK;
      end else if (i_head) begin
         o_rgb = COL_HEAD;
      end else begin
         case (i_code)
            CELL_P1:   o_rgb = COL_P1;
            CELL_P2:   o_rgb = COL_P2;
            CELL_WALL: o_rgb = COL_WALL;
            default:   o_rgb = COL_BLACK;
         endcase
      end
   end

endmodule

// File: rtl/tron_pixel_gen.sv
// Tron pixel-colour stage: turns VGA counters into arena cell reads and
// colours, keeping sync/bright aligned with a fixed 3-cycle latency.
module tron_pixel_gen
   import tron_pkg::*;
#(
   parameter int H_START   = 144,
   parameter int V_START   = 0,
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int TICK_LINE = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       hCount,
   input  logic [15:0]       vCount,
   input  logic              bright,
   input  logic              hSync,
   input  logic              vSync,
   input  logic [COL_W-1:0]  p1Col,
   input  logic [ROW_W-1:0]  p1Row,
   input  logic [COL_W-1:0]  p2Col,
   input  logic [ROW_W-1:0]  p2Row,
   output logic [ADDR_W-1:0] ramAddr,
   input  logic [1:0]        ramData,
   output logic [7:0]        rgb,
   output logic              hSyncOut,
   output logic              vSyncOut,
   output logic              brightOut,
   output logic              frameTick
);

   // {hSync, vSync, bright} reset pattern: syncs idle high, bright low
   localparam logic [2:0] SYNC_RST = 3'b110;

   logic [15:0]       w_hoff;
   logic [15:0]       w_voff;
   logic              w_active;
   logic              w_head;
   logic [COL_W-1:0]  w_col;
   logic [ROW_W-1:0]  w_row;
   logic [ADDR_W-1:0] w_addr;
   logic [7:0]        w_rgb;

   logic              r_active1;
   logic              r_head1;
   logic [2:0]        r_sync1;
   logic              r_active2;
   logic              r_head2;
   logic [1:0]        r_code2;
   logic [2:0]        r_sync2;
   logic [15:0]       r_prev_v;

   // Window offsets wrap for counts below the start, so one compare per axis bounds both sides
   always_comb begin
      w_hoff   = hCount - 16'(H_START);
      w_voff   = vCount - 16'(V_START);
      w_active = bright && (w_hoff < 16'(H_ACTIVE)) && (w_voff < 16'(V_ACTIVE));
      w_col    = w_hoff[CELL_SHIFT +: COL_W];
      w_row    = w_voff[CELL_SHIFT +: ROW_W];
      w_head   = w_active && (((w_col == p1Col) && (w_row == p1Row)) ||
                              ((w_col == p2Col) && (w_row == p2Row)));
      w_addr   = w_active ? cell_addr(w_row, w_col) : '0;
   end

   // S1: issue the RAM address and register activity, head hit and raw syncs
   always_ff @(posedge clk) begin
      if (!reset) begin
         ramAddr   <= '0;
         r_active1 <= 1'b0;
         r_head1   <= 1'b0;
         r_sync1   <= SYNC_RST;
      end else begin
         ramAddr   <= w_addr;
         r_active1 <= w_active;
         r_head1   <= w_head;
         r_sync1   <= {hSync, vSync, bright};
      end
   end

   // S2: capture the cell code returned for the S1 address
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_code2   <= 2'd0;
         r_active2 <= 1'b0;
         r_head2   <= 1'b0;
         r_sync2   <= SYNC_RST;
      end else begin
         r_code2   <= ramData;
         r_active2 <= r_active1;
         r_head2   <= r_head1;
         r_sync2   <= r_sync1;
      end
   end

   tron_color_map u_color_map (
      .i_code   (r_code2),
      .i_head   (r_head2),
      .i_active (r_active2),
      .o_rgb    (w_rgb)
   );

   // S3: register the colour together with the delayed syncs
   always_ff @(posedge clk) begin
      if (!reset) begin
         rgb                             <= 8'h00;
         {hSyncOut, vSyncOut, brightOut} <= SYNC_RST;
      end else begin
         rgb                             <= w_rgb;
         {hSyncOut, vSyncOut, brightOut} <= r_sync2;
      end
   end

   // Pulse once when vCount enters the tick line; staying on it holds the pulse off
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_prev_v  <= 16'd0;
         frameTick <= 1'b0;
      end else begin
         r_prev_v  <= vCount;
         frameTick <= (vCount == 16'(TICK_LINE)) && (r_prev_v != 16'(TICK_LINE));
      end
   end

endmodule
